ehl_word_serializer: RTL and testbench
======================================

// Module: ehl_word_serializer
// PURPOSE
//   Streams a BYTE_CNT-byte word out one byte per cycle, in big-endian (MSB byte first)
//   or little-endian (LSB byte first) order, selected per word.
//   Sits between word-wide datapaths and byte-wide links (UART/SPI/byte FIFOs).
//   It is the byte-stream transmit counterpart of the combinational endian swapper.
//   Valid/ready handshake on both sides; back-to-back words run with no idle cycle.
// PARAMETERS
//   BYTE_CNT  4  bytes per input word; legal range >=1
// PORTS
//   clk          input   1             clock; all logic on rising edge
//   rst          input   1             synchronous reset, active-high
//   s_valid      input   1             input word valid
//   s_ready      output  1             input word accepted when s_valid & s_ready
//   s_data       input   BYTE_CNT*8    input word
//   s_big_endian input   1             1: MSB byte first; 0: LSB byte first; sampled with s_data
//   m_valid      output  1             output byte valid
//   m_ready      input   1             downstream accepts byte when m_valid & m_ready
//   m_data       output  8             output byte
//   m_last       output  1             marks final byte of current word
//   busy         output  1             word held (state SEND)
// BEHAVIOUR
//   Reset: rst=1 at a clk edge -> state IDLE, idx=0, word register=0, m_valid=0, m_data=0,
//     m_last=0, busy=0. s_ready=0 while rst=1; 1 the first cycle rst=0.
//     Reset mid-word discards the remaining bytes; no partial word resumes.
//   State IDLE: s_ready=1, m_valid=0. Accept -> capture s_data and s_big_endian, idx=0,
//     go SEND. The first byte is valid in the cycle after the accept (latency 1).
//   State SEND: m_valid=1, busy=1; m_data is the byte at idx:
//     big: s_data[(BYTE_CNT-1-idx)*8 +: 8]   little: s_data[idx*8 +: 8] (captured copy).
//     m_last = (idx == BYTE_CNT-1).
//     m_valid & m_ready & !m_last -> idx+1.
//     m_valid & m_ready & m_last  -> word done. If s_valid in the same cycle: capture the
//       next word, idx=0, stay SEND (no bubble). Otherwise go IDLE.
//   s_ready is combinational: (state==IDLE) | (m_valid & m_ready & m_last), forced 0 by rst.
//     There is no other path from m_ready to s_ready.
//   Stall: while m_valid & !m_ready, m_data, m_last and idx hold stable.
//     The captured word and order are unaffected by s_data/s_big_endian changes.
//   idx width is clog2(BYTE_CNT), minimum 1 bit. It never exceeds BYTE_CNT-1 (no wrap past last).
//   BYTE_CNT=1: every byte has m_last=1; the order select has no effect.
//     Throughput is 1 word/cycle with m_ready held 1.
//   Steady-state throughput is 1 byte/cycle, i.e. BYTE_CNT cycles per word.
// TESTING
//   1. BYTE_CNT=4, word 0x11223344, big=1, m_ready=1
//      -> 0x11,0x22,0x33,0x44 on cycles 1..4; m_last only on 0x44.
//   2. Same word, big=0 -> 0x44,0x33,0x22,0x11; m_last on 0x11.
//   3. Two words offered back-to-back, m_ready=1
//      -> 8 consecutive valid bytes, no gap; s_ready=1 exactly in the last-byte cycles.
//   4. m_ready=0 for 3 cycles on byte 2 (0x22), s_data changed meanwhile
//      -> m_data holds 0x22; sequence resumes with the original 0x33,0x44.
//   5. rst=1 after the 2nd byte -> next cycle m_valid=0, busy=0;
//      the next word is streamed starting from its first byte.
//   6. BYTE_CNT=1, s_valid and m_ready held 1, words 0xA5,0x5A
//      -> one byte/cycle, m_last=1 on each; ordering flag ignored.

Source files
------------

// File: rtl/ehl_word_serializer.sv
// ehl_word_serializer
//   Streams a BYTE_CNT-byte word out one byte per cycle, MSB byte first
//   (big-endian) or LSB byte first (little-endian), chosen per word.
//   Valid/ready on both sides; a new word may be accepted in the same
//   cycle the last byte of the current word is taken, so back-to-back
//   words stream with no idle cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   s_valid      input word valid
//   s_ready      input word accepted when s_valid & s_ready (combinational)
//   s_data       input word, BYTE_CNT*8 bits
//   s_big_endian 1: MSB byte first, 0: LSB byte first; sampled with s_data
//   m_valid      output byte valid
//   m_ready      downstream accepts byte when m_valid & m_ready
//   m_data       output byte
//   m_last       final byte of the current word
//   busy         a word is held (state SEND)
module ehl_word_serializer #(
  parameter int BYTE_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BYTE_CNT*8-1:0] s_data,
  input  logic                  s_big_endian,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int W     = BYTE_CNT * 8;
  localparam int IDX_W = (BYTE_CNT > 1) ? $clog2(BYTE_CNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_CNT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     word;
  logic             big;

  // Byte at position i of word w in transmit order.
  function automatic logic [7:0] pick(input logic [W-1:0] w,
                                      input logic big_sel,
                                      input logic [IDX_W-1:0] i);
    int           pos;
    logic [W-1:0] sh;
    pos = big_sel ? (BYTE_CNT - 1 - int'(i)) : int'(i);
    sh  = w >> (8 * pos);
    return sh[7:0];
  endfunction

  logic             xfer;
  logic             advance;
  logic             done;
  logic             accept;
  logic [IDX_W-1:0] idx_next;
  logic [7:0]       first_byte;

  always_comb begin
    // NOTE: every always_comb output gets an unconditional value first so
    // no path through the block can leave it unassigned and infer a latch.
    xfer       = m_valid & m_ready;
    advance    = xfer & ~m_last;
    done       = xfer & m_last;
    // The only route from m_ready to s_ready is the last-byte handoff.
    s_ready    = ~rst & ((state == IDLE) | done);
    accept     = s_valid & s_ready;
    idx_next   = idx + IDX_W'(1);
    first_byte = pick(s_data, s_big_endian, '0);
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // The word register is cleared too, so nothing of an aborted word
      // can reappear on m_data.
      state   <= IDLE;
      idx     <= '0;
      word    <= '0;
      big     <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (accept) begin
        // Covers both the IDLE accept and the no-bubble handoff in SEND.
        state   <= SEND;
        word    <= s_data;
        big     <= s_big_endian;
        idx     <= '0;
        m_valid <= 1'b1;
        busy    <= 1'b1;
        m_data  <= first_byte;
        m_last  <= (LAST_IDX == '0);
      end else begin
        case (state)
          IDLE: begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
          end
          SEND: begin
            if (advance) begin
              idx    <= idx_next;
              m_data <= pick(word, big, idx_next);
              m_last <= (idx_next == LAST_IDX);
            end else if (done) begin
              state   <= IDLE;
              m_valid <= 1'b0;
              busy    <= 1'b0;
              m_last  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ehl_word_serializer.sv
// Testbench for ehl_word_serializer: a 4-byte instance and a 1-byte instance.
// Stimulus pushes expected bytes into per-instance queues; monitors pop and
// compare whenever a byte is transferred.
module tb_ehl_word_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-byte instance
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_big = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;

  // 1-byte instance
  logic        s_valid1 = 1'b0;
  logic        s_ready1;
  logic [7:0]  s_data1 = '0;
  logic        s_big1 = 1'b0;
  logic        m_valid1;
  logic        m_ready1 = 1'b1;
  logic [7:0]  m_data1;
  logic        m_last1;
  logic        busy1;

  ehl_word_serializer #(.BYTE_CNT(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_big_endian(s_big),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  ehl_word_serializer #(.BYTE_CNT(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .s_big_endian(s_big1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1),
    .busy(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q4[$];  // {last, data}
  logic [8:0] q1[$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitors: sample at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (q4.size() == 0) begin
        check("unexpected_byte4", {24'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = q4.pop_front();
        check("byte4_data", {24'd0, m_data}, {24'd0, e[7:0]});
        check("byte4_last", {31'd0, m_last}, {31'd0, e[8]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid1 && m_ready1) begin
      if (q1.size() == 0) begin
        check("unexpected_byte1", {24'd0, m_data1}, 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = q1.pop_front();
        check("byte1_data", {24'd0, m_data1}, {24'd0, e[7:0]});
        check("byte1_last", {31'd0, m_last1}, {31'd0, e[8]});
      end
    end
  end

  // Expected bytes for a 4-byte word, hand-ordered per endianness.
  task automatic push4(input logic [31:0] w, input logic big_sel);
    logic [7:0] b [4];
    if (big_sel) begin
      b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
    end else begin
      b[0] = w[7:0]; b[1] = w[15:8]; b[2] = w[23:16]; b[3] = w[31:24];
    end
    for (int i = 0; i < 4; i++) q4.push_back({(i == 3), b[i]});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] w, input logic big_sel);
    bit ok;
    ok = 1'b0;
    push4(w, big_sel);
    s_valid = 1'b1;
    s_data  = w;
    s_big   = big_sel;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!m_valid && q4.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_m_data",  {24'd0, m_data},  32'd0);
    check("rst_m_last",  {31'd0, m_last},  32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_rst", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;

    // 1: big-endian, latency 1
    send_word(32'h1122_3344, 1'b1);
    @(negedge clk);
    check("lat1_valid", {31'd0, m_valid}, 32'd1);
    check("lat1_busy",  {31'd0, busy},    32'd1);
    check("lat1_first", {24'd0, m_data},  32'h11);
    wait_drain();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 2: little-endian
    send_word(32'h1122_3344, 1'b0);
    wait_drain();

    // 3: back-to-back, no gap; s_ready only in last-byte cycles
    fork
      begin
        send_word(32'hA1A2_A3A4, 1'b1);
        send_word(32'hB1B2_B3B4, 1'b0);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (m_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("b2b_start", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clk);
          check("b2b_valid",  {31'd0, m_valid}, 32'd1);
          check("b2b_s_ready", {31'd0, s_ready}, {31'd0, (i == 3 || i == 7)});
        end
      end
    join
    wait_drain();

    // 4: stall on byte 0x22 while s_data changes
    send_word(32'h1122_3344, 1'b1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    s_data  = 32'hDEAD_BEEF;
    s_big   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data",  {24'd0, m_data},  32'h22);
      check("stall_last",  {31'd0, m_last},  32'd0);
      check("stall_valid", {31'd0, m_valid}, 32'd1);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain();

    // 5: reset after the second byte
    send_word(32'hC1C2_C3C4, 1'b1);
    @(posedge clk); #1;       // second byte now presented
    @(posedge clk); #1;       // second byte taken
    rst = 1'b1;
    q4.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_busy",  {31'd0, busy},    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_word(32'h5566_7788, 1'b0);
    @(negedge clk);
    check("post_rst_first", {24'd0, m_data}, 32'h88);
    wait_drain();

    // 6: BYTE_CNT=1, one word per cycle, order ignored
    s_valid1 = 1'b1;
    s_data1  = 8'hA5;
    s_big1   = 1'b1;
    q1.push_back({1'b1, 8'hA5});
    @(posedge clk); #1;
    s_data1 = 8'h5A;
    s_big1  = 1'b0;
    q1.push_back({1'b1, 8'h5A});
    @(negedge clk);
    check("bc1_valid0",  {31'd0, m_valid1}, 32'd1);
    check("bc1_s_ready", {31'd0, s_ready1}, 32'd1);
    @(posedge clk); #1;
    s_valid1 = 1'b0;
    @(negedge clk);
    check("bc1_valid1", {31'd0, m_valid1}, 32'd1);
    check("bc1_data1",  {24'd0, m_data1},  32'h5A);
    repeat (3) @(negedge clk);
    check("bc1_idle", {31'd0, m_valid1}, 32'd0);

    check("q4_empty", q4.size(), 32'd0);
    check("q1_empty", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
